alu_divider: RTL and testbench

ALU_DIVIDER -- requirements
Module: alu_divider

---
 rtl/alu_pkg.sv | 10 +
 rtl/div_trial_sub.sv | 11 +
 rtl/alu_divider.sv | 78 +++++++
 tb/tb_alu_divider.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared width, counter sizing and FSM state encoding for the divider
package alu_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W = $clog2(WIDTH_DEF) + 1;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: combinational trial subtraction a - b with borrow as the negative flag
module div_trial_sub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         neg
);
  assign {neg, diff} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/alu_divider.sv
// alu_divider: unsigned restoring shift-subtract divider, one quotient bit per clock, MSB first
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dq, dvs, dq_nx;
  logic [WIDTH:0]   rem, shifted, diff, rem_nx;
  logic             neg, last;
  // dq shifts dividend bits out of the top while quotient bits enter at the bottom
  assign shifted = {rem[WIDTH-1:0], dq[WIDTH-1]};
  div_trial_sub #(.W(WIDTH + 1)) u_sub (
    .a    (shifted),
    .b    ({1'b0, dvs}),
    .diff (diff),
    .neg  (neg)
  );
  assign rem_nx = neg ? shifted : diff;
  assign dq_nx  = {dq[WIDTH-2:0], ~neg};
  assign last   = cnt == CNT_W'(WIDTH - 1);
  assign busy   = state != IDLE;
  assign done   = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dq          <= '0;
      dvs         <= '0;
      rem         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dq  <= dividend;
          dvs <= divisor;
          rem <= '0;
          cnt <= '0;
          if (divisor == '0) begin
            state       <= DONE;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          rem <= rem_nx;
          dq  <= dq_nx;
          cnt <= cnt + CNT_W'(1);
          // the final iteration publishes its result directly so outputs never show partials
          if (last) begin
            state       <= DONE;
            quotient    <= dq_nx;
            remainder   <= rem_nx[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: directed vector table plus hand-written corner sequences for alu_divider
module tb_alu_divider;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend, divisor, quotient, remainder;
  logic       busy, done, div_by_zero;
  int checks = 0;
  int failures = 0;

  alu_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // call at #1 after a posedge with the DUT idle; returns the number of edges from acceptance to done
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    lat      = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        chk("busy_after_start", busy, 1);
      end
    end while (!done && lat < 20);
    if (!done) chk("done_timeout", done, 1);
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    @(posedge clk); #1;
    chk("done_single_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  vec_t vecs[11];
  logic [7:0] q, r;
  logic dz;
  int lat;
  int dones;

  initial begin
    vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 9};
    vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9};
    vecs[2]  = '{8'd3,   8'd10,  8'd0,   8'd3,   1'b0, 9};
    vecs[3]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9};
    vecs[4]  = '{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 1};
    vecs[5]  = '{8'd6,   8'd3,   8'd2,   8'd0,   1'b0, 9};
    vecs[6]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 9};
    vecs[7]  = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1, 1};
    vecs[8]  = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0, 9};
    vecs[9]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 9};
    vecs[10] = '{8'd17,  8'd16,  8'd1,   8'd1,   1'b0, 9};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_div(vecs[i].a, vecs[i].b, q, r, dz, lat);
      chk($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      chk($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dz", i), dz, vecs[i].dz);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // 200/9 with a 1/1 start pulsed mid-run and again during DONE
    dividend = 8'd200; divisor = 8'd9; start = 1'b1; lat = 0; dones = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      if (lat == 3) begin
        dividend = 8'd1; divisor = 8'd1; start = 1'b1;
      end
      if (lat == 4) begin
        chk("hold_quotient_mid_run", quotient, 1);
        chk("hold_remainder_mid_run", remainder, 1);
      end
      if (done) dones++;
    end while (!done && lat < 20);
    chk("ignore_latency", lat, 9);
    chk("ignore_quotient", quotient, 22);
    chk("ignore_remainder", remainder, 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ignore_done_start_busy", busy, 0);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("ignore_single_done", dones, 1);
    chk("ignore_hold_quotient", quotient, 22);

    // reset asserted mid-run abandons the operation
    dividend = 8'd77; divisor = 8'd5; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("prereset_busy", busy, 1);
    chk("prereset_quotient", quotient, 22);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_quotient", quotient, 0);
    chk("async_rst_remainder", remainder, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_dz", div_by_zero, 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("no_done_after_reset", dones, 0);

    // start presented on the very first edge after release
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_div(8'd77, 8'd5, q, r, dz, lat);
    chk("fresh_quotient", q, 15);
    chk("fresh_remainder", r, 2);
    chk("fresh_latency", lat, 9);

    // back-to-back random pairs against the arithmetic reference
    for (int k = 0; k < 300; k++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_div(a, b, q, r, dz, lat);
      chk($sformatf("rand_%0d/%0d_quotient", a, b), q, a / b);
      chk($sformatf("rand_%0d/%0d_remainder", a, b), r, a % b);
      chk($sformatf("rand_%0d/%0d_dz", a, b), dz, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
